// File: rtl/pitch_pkg.sv
// ---------------------------------------------------------------------------
// pitch_pkg
// Shared definitions for the pitch-detection path.
//   scan_state_t   : sequencer states of peak_scan_ctrl
//   BIN_W          : default FFT bin address / index width
//   MAG_CLAMP      : largest magnitude the serial peak finder can compare
//   RD_LAT_DEFAULT : default spectrum RAM read latency (cycles)
//   CMP_W_DEFAULT  : default finder compare width
// ---------------------------------------------------------------------------
package pitch_pkg;

   localparam int          BIN_W          = 9;
   localparam int          RD_LAT_DEFAULT = 2;
   localparam int          CMP_W_DEFAULT  = 18;
   localparam logic [17:0] MAG_CLAMP      = 18'h3FFFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      CAPT  = 3'd3,
      DONE  = 3'd4
   } scan_state_t;

   function automatic logic is_busy(input scan_state_t s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/lat_pipe.sv
// ---------------------------------------------------------------------------
// lat_pipe
// Fixed-depth shift register that follows each RAM read through the RAM
// latency so the read's tags line up with its returning data.
//   clk   in      : clock
//   rst_n in      : asynchronous active-low reset
//   clr   in      : synchronous flush of every stage
//   din   in  [W] : tag entering with the read strobe
//   dout  out [W] : tag emerging DEPTH cycles later
// ---------------------------------------------------------------------------
module lat_pipe #(
   parameter int DEPTH = 2,
   parameter int W     = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] chain [DEPTH+1];

   assign chain[0] = din;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q_reg <= '0;
         end else if (clr) begin
            q_reg <= '0;
         end else begin
            q_reg <= chain[gi];
         end
      end

      assign chain[gi+1] = q_reg;
   end

   assign dout = chain[DEPTH];

endmodule

// File: rtl/peak_scan_ctrl.sv
// ---------------------------------------------------------------------------
// peak_scan_ctrl
// Sweeps a window of FFT magnitude bins out of the spectrum RAM into the
// serial peak finder, then captures the winning bin.
//   scan_req/lo_bin/hi_bin in : start a scan of bins lo_bin..hi_bin
//   abort                  in : cancel a scan in progress
//   ram_rd_en/ram_addr     out: spectrum RAM read port
//   ram_data               in : RAM data, RD_LAT cycles after the strobe
//   pf_start/pf_data/pf_index out: finder stream (index relative to lo_bin)
//   pf_peak_index          in : finder result (offset)
//   busy/done/err          out: status; err qualifies done
//   peak_bin/peak_valid    out: absolute winning bin of last good scan
// ---------------------------------------------------------------------------
module peak_scan_ctrl
   import pitch_pkg::*;
#(
   parameter int ADDR_W = BIN_W,
   parameter int DATA_W = 32,
   parameter int RD_LAT = RD_LAT_DEFAULT,
   parameter int CMP_W  = CMP_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scan_req,
   input  logic              abort,
   input  logic [ADDR_W-1:0] lo_bin,
   input  logic [ADDR_W-1:0] hi_bin,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic              pf_start,
   output logic [DATA_W-1:0] pf_data,
   output logic [ADDR_W-1:0] pf_index,
   input  logic [ADDR_W-1:0] pf_peak_index,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] peak_bin,
   output logic              peak_valid
);

   localparam int DRN_W  = $clog2(RD_LAT + 1);
   localparam int PIPE_W = ADDR_W + 2;
   // Largest value the finder can order correctly; anything larger would
   // wrap in its narrow compare and lose to smaller bins.
   localparam logic [DATA_W-1:0] CLAMP_MAX =
      (CMP_W == $bits(MAG_CLAMP)) ? DATA_W'(MAG_CLAMP)
                                  : DATA_W'((64'd1 << CMP_W) - 64'd1);

   scan_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] lo_reg, hi_reg, off_reg;
   logic [DRN_W-1:0]  drain_reg;
   logic              err_reg;
   logic [ADDR_W-1:0] peak_bin_reg;
   logic              peak_valid_reg;

   logic              accept;
   logic              win_ok;
   logic [ADDR_W-1:0] rd_addr;
   logic              last_rd;
   logic              drain_last;
   logic              rd_en;

   logic [PIPE_W-1:0] pipe_in, pipe_out;
   logic              pipe_valid, pipe_first;
   logic [ADDR_W-1:0] pipe_off;
   logic [DATA_W-1:0] clamped;

   assign accept     = (state_reg == IDLE) && scan_req;
   assign win_ok     = (lo_bin <= hi_bin);
   // Comparing the address rather than counting N avoids overflow when the
   // window spans all 2^ADDR_W bins.
   assign rd_addr    = lo_reg + off_reg;
   assign last_rd    = (rd_addr == hi_reg);
   assign drain_last = (drain_reg == DRN_W'(RD_LAT - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            // A request in IDLE takes priority over abort.
            if (scan_req) begin
               state_next = win_ok ? READ : DONE;
            end
         end
         READ: begin
            if (abort) begin
               state_next = IDLE;
            end else if (last_rd) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (drain_last) begin
               state_next = CAPT;
            end
         end
         CAPT: begin
            state_next = abort ? IDLE : DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      rd_en = 1'b0;
      done  = 1'b0;
      busy  = is_busy(state_reg);
      unique case (state_reg)
         READ:    rd_en = 1'b1;
         DONE:    done  = 1'b1;
         default: ;
      endcase
   end

   assign ram_rd_en = rd_en;
   assign ram_addr  = rd_en ? rd_addr : '0;
   assign err       = done & err_reg;

   // ---------------- window / counters / result ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_reg         <= '0;
         hi_reg         <= '0;
         off_reg        <= '0;
         drain_reg      <= '0;
         err_reg        <= 1'b0;
         peak_bin_reg   <= '0;
         peak_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            lo_reg         <= lo_bin;
            hi_reg         <= hi_bin;
            off_reg        <= '0;
            drain_reg      <= '0;
            err_reg        <= !win_ok;
            peak_valid_reg <= 1'b0;
         end
         if (state_reg == READ && !last_rd) begin
            off_reg <= off_reg + 1'b1;
         end
         if (state_reg == DRAIN) begin
            drain_reg <= drain_reg + 1'b1;
         end
         if (state_reg == CAPT && !abort) begin
            peak_bin_reg   <= lo_reg + pf_peak_index;
            peak_valid_reg <= 1'b1;
         end
      end
   end

   assign peak_bin   = peak_bin_reg;
   assign peak_valid = peak_valid_reg;

   // ---------------- read-tag delay line ----------------
   assign pipe_in = {rd_en, rd_en && (off_reg == '0), off_reg};

   lat_pipe #(
      .DEPTH (RD_LAT),
      .W     (PIPE_W)
   ) u_lat_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort && busy),
      .din   (pipe_in),
      .dout  (pipe_out)
   );

   assign pipe_valid = pipe_out[PIPE_W-1];
   assign pipe_first = pipe_out[PIPE_W-2];
   assign pipe_off   = pipe_out[ADDR_W-1:0];

   // The finder compares continuously, so anything but a live datum is
   // driven as 0 to keep it from updating outside the sweep.
   assign clamped  = (ram_data > CLAMP_MAX) ? CLAMP_MAX : ram_data;
   assign pf_data  = pipe_valid ? clamped : '0;
   assign pf_start = pipe_valid & pipe_first;
   assign pf_index = pipe_valid ? pipe_off : '0;

endmodule

// File: tb/tb_peak_scan_ctrl.sv
module tb_peak_scan_ctrl;

   localparam int RD_LAT = 2;
   localparam longint CLAMP = 64'h3FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scan_req, abort;
   logic [8:0]  lo_bin, hi_bin;
   logic        ram_rd_en;
   logic [8:0]  ram_addr;
   logic [31:0] ram_data;
   logic        pf_start;
   logic [31:0] pf_data;
   logic [8:0]  pf_index;
   logic [8:0]  pf_peak_index;
   logic        busy, done, err;
   logic [8:0]  peak_bin;
   logic        peak_valid;

   int compared   = 0;
   int mismatched = 0;
   int model_peak_bin;

   logic [31:0] mem [512];
   logic [31:0] rdq0, rdq1;
   logic [17:0] fmax;
   logic [8:0]  fidx;

   always #5 clk = ~clk;

   peak_scan_ctrl #(
      .ADDR_W (9),
      .DATA_W (32),
      .RD_LAT (RD_LAT),
      .CMP_W  (18)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .scan_req      (scan_req),
      .abort         (abort),
      .lo_bin        (lo_bin),
      .hi_bin        (hi_bin),
      .ram_rd_en     (ram_rd_en),
      .ram_addr      (ram_addr),
      .ram_data      (ram_data),
      .pf_start      (pf_start),
      .pf_data       (pf_data),
      .pf_index      (pf_index),
      .pf_peak_index (pf_peak_index),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .peak_bin      (peak_bin),
      .peak_valid    (peak_valid)
   );

   // Spectrum RAM with two-cycle read latency; garbage when not reading.
   always @(posedge clk) begin
      rdq0 <= ram_rd_en ? mem[ram_addr] : $urandom;
      rdq1 <= rdq0;
   end
   assign ram_data = rdq1;

   // Serial peak finder: 18-bit compare, index reset to 0 on start,
   // compares every cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fmax <= '0;
         fidx <= '0;
      end else if (pf_start) begin
         fmax <= pf_data[17:0];
         fidx <= '0;
      end else if (pf_data[17:0] > fmax) begin
         fmax <= pf_data[17:0];
         fidx <= pf_index;
      end
   end
   assign pf_peak_index = fidx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int lo, input int hi);
      for (int b = lo; b <= hi; b++) begin
         mem[b] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000));
      end
   endtask

   // Issues a request in the current cycle (caller is #1 after an edge) and
   // follows it to the first IDLE cycle after completion.
   // mode: 0 plain, 1 extra scan_req while busy, 2 abort together with request.
   task automatic run_scan(input int lo, input int hi, input int mode, input string tag);
      int n, exp_done, exp_peak, best_idx;
      longint best, m;
      int done_cnt, done_cyc, rd_cnt, start_cnt, start_cyc;
      bit valid, addr_ok, idx_ok;
      logic [8:0] pb;
      logic pv, er, busy_at_done, busy_after;
      valid = (lo <= hi);
      best_idx = 0;
      if (valid) begin
         n = hi - lo + 1;
         best = -1;
         for (int k = 0; k < n; k++) begin
            m = longint'(mem[lo + k]);
            if (m > CLAMP) m = CLAMP;
            if (m > best) begin
               best = m;
               best_idx = k;
            end
         end
         exp_peak = lo + best_idx;
         exp_done = n + RD_LAT + 2;
      end else begin
         n = 0;
         exp_peak = model_peak_bin;
         exp_done = 1;
      end
      scan_req = 1'b1;
      lo_bin = 9'(lo);
      hi_bin = 9'(hi);
      if (mode == 2) abort = 1'b1;
      @(posedge clk); #1;
      scan_req = 1'b0;
      abort = 1'b0;
      lo_bin = 9'($urandom);
      hi_bin = 9'($urandom);
      done_cnt = 0; done_cyc = 0; rd_cnt = 0; start_cnt = 0; start_cyc = 0;
      addr_ok = 1; idx_ok = 1;
      pb = 'x; pv = 'x; er = 'x; busy_at_done = 'x; busy_after = 'x;
      for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
         if (ram_rd_en) begin
            if (ram_addr !== 9'(lo + rd_cnt) || cyc != rd_cnt + 1) addr_ok = 0;
            rd_cnt++;
         end
         if (pf_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (pf_index !== 9'd0) idx_ok = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            pb = peak_bin;
            pv = peak_valid;
            er = err;
         end
         if (cyc == exp_done) busy_at_done = busy;
         if (cyc == exp_done + 1) busy_after = busy;
         if (mode == 1 && cyc == 3) begin
            scan_req = 1'b1;
            lo_bin = 9'd0;
            hi_bin = 9'd0;
         end
         if (cyc == 4) scan_req = 1'b0;
         if (cyc != exp_done + 1) begin
            @(posedge clk); #1;
         end
      end
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
      check({tag, "_read_count"}, 64'(rd_cnt), 64'(n));
      check({tag, "_read_addr"}, 64'(addr_ok), 64'd1);
      check({tag, "_start_count"}, 64'(start_cnt), 64'(valid));
      check({tag, "_start_cycle"}, 64'(start_cyc), valid ? 64'(1 + RD_LAT) : 64'd0);
      check({tag, "_start_index"}, 64'(idx_ok), 64'd1);
      check({tag, "_err"}, 64'(er), 64'(!valid));
      check({tag, "_peak_bin"}, 64'(pb), 64'(exp_peak));
      check({tag, "_peak_valid"}, 64'(pv), 64'(valid));
      check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
      check({tag, "_busy_after"}, 64'(busy_after), 64'd0);
      if (valid) model_peak_bin = exp_peak;
      $display("scan %s lo=%0d hi=%0d mode=%0d peak_bin=%0d exp=%0d done_cyc=%0d exp=%0d",
               tag, lo, hi, mode, pb, exp_peak, done_cyc, exp_done);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, 64'(ram_rd_en), 64'd0);
      check({tag, "_addr"}, 64'(ram_addr), 64'd0);
      check({tag, "_pf_start"}, 64'(pf_start), 64'd0);
      check({tag, "_pf_data"}, 64'(pf_data), 64'd0);
      check({tag, "_pf_index"}, 64'(pf_index), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
      check({tag, "_peak_valid"}, 64'(peak_valid), 64'd0);
   endtask

   initial begin
      int lo, hi, done_seen;
      rst_n = 1'b0;
      scan_req = 1'b0;
      abort = 1'b0;
      lo_bin = '0;
      hi_bin = '0;
      model_peak_bin = 0;
      for (int b = 0; b < 512; b++) mem[b] = '0;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      $display("reset state checked");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed windows
      mem[10] = 32'd5; mem[11] = 32'd9; mem[12] = 32'd300; mem[13] = 32'd7; mem[14] = 32'd1;
      run_scan(10, 14, 0, "win10_14");
      mem[100] = 32'd42;
      run_scan(100, 100, 0, "single100");
      for (int b = 0; b < 512; b++) mem[b] = 32'($urandom_range(0, 1000));
      mem[200] = 32'h0004_0000;
      mem[201] = 32'h0003_FFFF;
      run_scan(0, 511, 0, "clamp_full");
      run_scan(20, 19, 0, "bad_window");

      // Random windows, back-to-back
      for (int i = 0; i < 6; i++) begin
         lo = $urandom_range(0, 511);
         hi = $urandom_range(lo, (lo + 40 > 511) ? 511 : lo + 40);
         fill(lo, hi);
         run_scan(lo, hi, (i == 2) ? 2 : 0, $sformatf("rand%0d", i));
      end

      // Abort mid-read
      fill(0, 31);
      scan_req = 1'b1; lo_bin = 9'd0; hi_bin = 9'd31;
      @(posedge clk); #1;
      scan_req = 1'b0;
      done_seen = 0;
      for (int cyc = 1; cyc < 10; cyc++) begin
         if (done) done_seen++;
         @(posedge clk); #1;
      end
      abort = 1'b1;
      if (done) done_seen++;
      @(posedge clk); #1;
      abort = 1'b0;
      if (done) done_seen++;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_rd_en", 64'(ram_rd_en), 64'd0);
      check("abort_pf_data", 64'(pf_data), 64'd0);
      check("abort_pf_start", 64'(pf_start), 64'd0);
      check("abort_peak_valid", 64'(peak_valid), 64'd0);
      check("abort_no_done", 64'(done_seen), 64'd0);
      $display("abort on cycle 10 checked, done_seen=%0d", done_seen);
      @(posedge clk); #1;
      run_scan(0, 31, 0, "after_abort");

      // Asynchronous reset mid-read
      fill(0, 31);
      scan_req = 1'b1; lo_bin = 9'd0; hi_bin = 9'd31;
      @(posedge clk); #1;
      scan_req = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      $display("reset during read checked");
      model_peak_bin = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Request during busy must be ignored
      lo = $urandom_range(0, 400);
      hi = lo + $urandom_range(3, 60);
      fill(lo, hi);
      run_scan(lo, hi, 1, "busy_req");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
